// File: rtl/pixel_splitter.sv
// pixel_splitter: unpacks DATA_WIDTH-bit words into PIXEL_WIDTH-bit pixels,
// least-significant pixel first, one pixel per output handshake.
// One word is held in a shift register and one in a skid buffer. This lets a
// new word be accepted while the current one is still draining, so the
// output can run at one pixel per cycle.
module pixel_splitter #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [PIXEL_WIDTH-1:0] pixel,
    output logic                   is_pixel_valid,
    input  logic                   pixel_ready,
    output logic                   is_last
);

    localparam int PIXEL_NUMBER = DATA_WIDTH / PIXEL_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] LAST_INDEX = COUNTER_WIDTH'(PIXEL_NUMBER - 1);

    // EMPTY: nothing held; ACTIVE: shift register holds a word;
    // FULL: shift register and skid buffer both hold a word.
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] w_count_next;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic [DATA_WIDTH-1:0]    w_shift_next;
    logic [DATA_WIDTH-1:0]    r_skid;
    logic [DATA_WIDTH-1:0]    w_skid_next;

    logic                     w_accept;
    logic                     w_take;
    logic                     w_at_last;
    logic [DATA_WIDTH-1:0]    w_shifted;

    // Outputs are gated by reset, so nothing leaks out while a mid-word reset
    // is being applied. Ready depends only on state, never on data_valid.
    assign data_ready     = !reset && (r_state != ST_FULL);
    assign is_pixel_valid = !reset && (r_state != ST_EMPTY);
    assign pixel          = is_pixel_valid ? r_shift[PIXEL_WIDTH-1:0] : '0;
    assign w_at_last      = (r_count == LAST_INDEX);
    assign is_last        = is_pixel_valid && w_at_last;

    assign w_accept  = data_valid && data_ready;
    assign w_take    = is_pixel_valid && pixel_ready;
    assign w_shifted = r_shift >> PIXEL_WIDTH;

    // Next-state, counter and datapath selection for the three occupancy states.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves a value
        // unassigned. A missing default would infer a latch.
        w_state_next = r_state;
        w_count_next = r_count;
        w_shift_next = r_shift;
        w_skid_next  = r_skid;

        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_shift_next = data;
                    w_count_next = '0;
                    w_state_next = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (w_take && w_at_last) begin
                    w_count_next = '0;
                    if (w_accept) begin
                        // The last pixel leaves as the next word arrives: swap in place.
                        w_shift_next = data;
                    end else begin
                        w_shift_next = '0;
                        w_state_next = ST_EMPTY;
                    end
                end else begin
                    if (w_take) begin
                        w_shift_next = w_shifted;
                        w_count_next = r_count + COUNTER_WIDTH'(1);
                    end
                    if (w_accept) begin
                        w_skid_next  = data;
                        w_state_next = ST_FULL;
                    end
                end
            end

            ST_FULL: begin
                if (w_take) begin
                    if (w_at_last) begin
                        w_shift_next = r_skid;
                        w_count_next = '0;
                        w_state_next = ST_ACTIVE;
                    end else begin
                        w_shift_next = w_shifted;
                        w_count_next = r_count + COUNTER_WIDTH'(1);
                    end
                end
            end

            default: begin
                w_state_next = ST_EMPTY;
                w_count_next = '0;
                w_shift_next = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update together from the values seen before the edge.
        if (reset) begin
            r_state <= ST_EMPTY;
            r_count <= '0;
            r_shift <= '0;
            // NOTE: the skid buffer is cleared as well, so a word caught
            // mid-flight by reset can never reappear later.
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_shift <= w_shift_next;
            r_skid  <= w_skid_next;
        end
    end

endmodule

// File: tb/tb_pixel_splitter.sv
// tb_pixel_splitter: directed and randomized stimulus for pixel_splitter.
// A queue-based reference model tracks every pixel owed to the output. A
// monitor compares each cycle's outputs against the model and re-merges the
// emitted pixels into words.
module tb_pixel_splitter;

    localparam int PW = 8;
    localparam int DW = 32;
    localparam int PN = DW / PW;

    logic          clock;
    logic          reset;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          data_ready;
    logic [PW-1:0] pixel;
    logic          is_pixel_valid;
    logic          pixel_ready;
    logic          is_last;

    pixel_splitter #(
        .PIXEL_WIDTH  (PW),
        .DATA_WIDTH   (DW),
        .COUNTER_WIDTH(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data          (data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .pixel         (pixel),
        .is_pixel_valid(is_pixel_valid),
        .pixel_ready   (pixel_ready),
        .is_last       (is_last)
    );

    typedef struct {
        logic [PW-1:0] pix;
        logic          last;
    } pix_t;

    pix_t          pix_q[$];   // pixels owed to the output, in order
    logic [DW-1:0] word_q[$];  // accepted words awaiting re-merge
    logic [PW-1:0] seen_q[$];  // pixels actually taken from the DUT
    logic [DW-1:0] asm_word;
    int            asm_n;
    int            n_checks;
    int            n_errors;
    bit            rdy_rand;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor. Outputs are sampled 3 time units after the
    // falling edge, once the inputs are stable for the coming rising edge.
    initial begin
        logic exp_valid;
        logic exp_ready;
        pix_t p;
        asm_n    = 0;
        asm_word = '0;
        forever begin
            @(negedge clock);
            #3;
            exp_valid = !reset && (pix_q.size() > 0);
            // Two words are held (state FULL) once more than one word of pixels is owed.
            exp_ready = !reset && (pix_q.size() <= PN);
            check("data_ready", data_ready, exp_ready);
            check("is_pixel_valid", is_pixel_valid, exp_valid);
            if (exp_valid) begin
                check("pixel", pixel, pix_q[0].pix);
                check("is_last", is_last, pix_q[0].last);
            end else begin
                check("idle_pixel", pixel, 0);
                check("idle_is_last", is_last, 0);
            end

            if (reset) begin
                pix_q.delete();
                word_q.delete();
                asm_n = 0;
            end else begin
                if (exp_valid && pixel_ready) begin
                    p = pix_q.pop_front();
                    seen_q.push_back(pixel);
                    asm_word[asm_n*PW +: PW] = pixel;
                    asm_n++;
                    if (asm_n == PN) begin
                        if (word_q.size() > 0)
                            check("merged_word", asm_word, word_q.pop_front());
                        else
                            check("merged_word_extra", asm_word, 32'hxxxx_xxxx);
                        asm_n = 0;
                    end
                end
                if (data_valid && exp_ready) begin
                    for (int i = 0; i < PN; i++) begin
                        p.pix  = data[i*PW +: PW];
                        p.last = (i == PN - 1);
                        pix_q.push_back(p);
                    end
                    word_q.push_back(data);
                end
            end
        end
    end

    // Random downstream backpressure, active only in the random phase.
    initial begin
        forever begin
            @(negedge clock);
            if (rdy_rand) pixel_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Global time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic dv, input logic [DW-1:0] d, input logic pr);
        @(negedge clock);
        data_valid = dv;
        data       = d;
        if (!rdy_rand) pixel_ready = pr;
    endtask

    // Present a word and hold it until accepted; returns after the accepting edge.
    task automatic send_word(input logic [DW-1:0] w, output int waits);
        waits = 0;
        @(negedge clock);
        data_valid = 1'b1;
        data       = w;
        #2;
        while (!data_ready) begin
            if (waits >= 64) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout word=%0h waited=%0d", w, waits);
                break;
            end
            @(negedge clock);
            #2;
            waits++;
        end
        @(posedge clock);
    endtask

    task automatic check_seen(input string tag, input int n, input logic [63:0] exp_pix);
        check({tag, "_count"}, seen_q.size(), n);
        for (int i = 0; i < n && i < seen_q.size(); i++)
            check(tag, seen_q[i], exp_pix[i*PW +: PW]);
    endtask

    initial begin
        int waits;
        int idle;
        n_checks    = 0;
        n_errors    = 0;
        rdy_rand    = 1'b0;
        reset       = 1'b1;
        data_valid  = 1'b1;
        data        = 32'hDEAD_BEEF;
        pixel_ready = 1'b1;

        // T1: reset held for two edges with data_valid high.
        @(negedge clock);
        @(negedge clock);
        reset      = 1'b0;
        data_valid = 1'b0;
        #3;
        check("t1_ready_after_reset", data_ready, 1);
        check("t1_valid_after_reset", is_pixel_valid, 0);

        // T2: single word, output always ready.
        seen_q.delete();
        send_word(32'h4433_2211, waits);
        for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1);
        check_seen("t2_pixels", 4, 64'h4433_2211);

        // T3: two back-to-back words; the second must not wait.
        seen_q.delete();
        send_word(32'h4433_2211, waits);
        send_word(32'h8877_6655, waits);
        check("t3_second_word_waits", waits, 0);
        for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1);
        check_seen("t3_pixels", 8, 64'h8877_6655_4433_2211);

        // T4: stall on 0x22 for five cycles while the next word lands in skid.
        seen_q.delete();
        drive(1'b1, 32'h4433_2211, 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, 32'h8877_6655, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0);
            #3;
            check("t4_hold_pixel", pixel, 8'h22);
            check("t4_full_not_ready", data_ready, 0);
        end
        for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1);
        check_seen("t4_pixels", 8, 64'h8877_6655_4433_2211);

        // T5: reset after 0x22 is taken with the skid full.
        drive(1'b1, 32'h4433_2211, 1'b1);
        drive(1'b1, 32'h8877_6655, 1'b1);
        drive(1'b0, '0, 1'b1);
        @(negedge clock);
        reset       = 1'b1;
        pixel_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #3;
        check("t5_valid_after_reset", is_pixel_valid, 0);
        seen_q.delete();
        pixel_ready = 1'b1;
        send_word(32'hDDCC_BBAA, waits);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1);
        check_seen("t5_pixels", 4, 64'hDDCC_BBAA);

        // T6: random words, random source gaps and random backpressure.
        rdy_rand = 1'b1;
        for (int w = 0; w < 300; w++) begin
            idle = $urandom_range(0, 3);
            for (int i = 0; i < idle; i++) drive(1'b0, '0, 1'b1);
            send_word($urandom, waits);
        end
        drive(1'b0, '0, 1'b1);
        rdy_rand    = 1'b0;
        pixel_ready = 1'b1;
        for (int i = 0; i < 40 && pix_q.size() > 0; i++) drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("t6_pixels_drained", pix_q.size(), 0);
        check("t6_words_merged", word_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
